// File: rtl/carbon_init_seq.sv
// ---------------------------------------------------------------------------
// carbon_init_seq
//
// Purpose : Boot-time CSR initialisation sequencer. The core is held in halt
//           while a parameter table of (address, data) pairs is written
//           through a CSR master. Faulted accesses are retried up to
//           MAX_RETRY extra times per entry. After the last entry the core
//           is released with a one-cycle run pulse. An entry that exhausts
//           its retries aborts the table and keeps the core halted.
//
// Optional feature : define CARBON_INIT_SEQ_VERIFY_EN to read back every
//           entry after its write. A read-back fault or a data mismatch
//           counts as a failed attempt and the write is retried.
//
// Ports   :
//   clk          in   clock; every register is updated on its rising edge
//   rst          in   synchronous active-high reset
//   restart      in   re-run the table (honoured in DONE/FAULT only)
//   csr_start    out  one-cycle access strobe to the CSR master
//   csr_write    out  1 = write, 0 = read (read only with verify enabled)
//   csr_addr     out  [31:0] access address, held until the next access
//   csr_wdata    out  [31:0] write data, held until the next access
//   csr_busy     in   CSR master busy; no strobe is issued while high
//   csr_done     in   access-complete pulse
//   csr_fault    in   access faulted, qualified by csr_done
//   csr_rdata    in   [31:0] read data, qualified by csr_done
//   halt_req     out  hold the core halted
//   run_pulse    out  one-cycle core release strobe
//   init_done    out  sticky: table completed
//   init_fault   out  sticky: table aborted
//   fault_index  out  [7:0] index of the entry that aborted the table
// ---------------------------------------------------------------------------
module carbon_init_seq #(
   parameter int          N_ENTRIES             = 8,
   parameter int          N_USED                = 6,
   parameter logic [31:0] INIT_ADDR  [N_ENTRIES] = '{default: 32'h0},
   parameter logic [31:0] INIT_WDATA [N_ENTRIES] = '{default: 32'h0},
   parameter int          MAX_RETRY             = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   output logic        csr_start,
   output logic        csr_write,
   output logic [31:0] csr_addr,
   output logic [31:0] csr_wdata,
   input  logic        csr_busy,
   input  logic        csr_done,
   input  logic        csr_fault,
   input  logic [31:0] csr_rdata,
   output logic        halt_req,
   output logic        run_pulse,
   output logic        init_done,
   output logic        init_fault,
   output logic [7:0]  fault_index
);

   localparam int IW   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int LAST = (N_USED > 0) ? (N_USED - 1) : 0;

   typedef enum logic [2:0] {
      S_ISSUE   = 3'd0,
      S_WAIT    = 3'd1,
      S_VISSUE  = 3'd2,
      S_VWAIT   = 3'd3,
      S_RELEASE = 3'd4,
      S_DONE    = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [RW-1:0]   r_retry;
   logic            r_start;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic            r_halt;
   logic            r_run;
   logic            r_done;
   logic            r_fault;
   logic [7:0]      r_fidx;

   logic            w_last;
   logic            w_retry_ok;
   logic            w_bad;      // completed attempt counts as a failure
   logic            w_adv;      // completed attempt finishes the entry

   assign w_last     = (r_idx == IW'(LAST));
   assign w_retry_ok = (r_retry < RW'(MAX_RETRY));

`ifdef CARBON_INIT_SEQ_VERIFY_EN
   logic r_write;
   logic w_rb_ok;

   assign w_rb_ok = (csr_rdata == INIT_WDATA[r_idx]);
   // A write that completes cleanly moves on to its read-back; only the
   // read-back completion finishes the entry.
   assign w_bad   = csr_fault || ((r_state == S_VWAIT) && !w_rb_ok);
   assign w_adv   = !w_bad && (r_state == S_VWAIT);
   assign csr_write = r_write;
`else
   logic w_unused;

   assign w_unused  = ^csr_rdata;
   assign w_bad     = csr_fault;
   assign w_adv     = !csr_fault;
   assign csr_write = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ISSUE;
         r_idx   <= '0;
         r_retry <= '0;
         r_start <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_halt  <= 1'b1;
         r_run   <= 1'b0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         r_fidx  <= '0;
`ifdef CARBON_INIT_SEQ_VERIFY_EN
         r_write <= 1'b1;
`endif
      end else begin
         // Strobes default low so each is exactly one cycle wide.
         r_start <= 1'b0;
         r_run   <= 1'b0;
         case (r_state)
            S_ISSUE: begin
               if (N_USED == 0) begin
                  // Empty table: release straight away, no CSR traffic.
                  r_state <= S_RELEASE;
                  r_run   <= 1'b1;
                  r_halt  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (!csr_busy) begin
                  r_start <= 1'b1;
                  r_addr  <= INIT_ADDR[r_idx];
                  r_wdata <= INIT_WDATA[r_idx];
`ifdef CARBON_INIT_SEQ_VERIFY_EN
                  r_write <= 1'b1;
`endif
                  r_state <= S_WAIT;
               end
            end
`ifdef CARBON_INIT_SEQ_VERIFY_EN
            S_VISSUE: begin
               if (!csr_busy) begin
                  r_start <= 1'b1;
                  r_write <= 1'b0;
                  r_state <= S_VWAIT;
               end
            end
`endif
            S_WAIT, S_VWAIT: begin
               // csr_done is only looked at here, so strays elsewhere vanish.
               if (csr_done) begin
                  if (w_bad) begin
                     if (w_retry_ok) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= S_ISSUE;
                     end else begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_fidx  <= 8'(r_idx);
                     end
                  end else if (w_adv) begin
                     r_retry <= '0;
                     if (w_last) begin
                        // Outputs flip together with the entry into RELEASE.
                        r_state <= S_RELEASE;
                        r_run   <= 1'b1;
                        r_halt  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_ISSUE;
                     end
                  end else begin
                     r_state <= S_VISSUE;
                  end
               end
            end
            S_RELEASE: begin
               r_state <= S_DONE;
            end
            S_DONE, S_FAULT: begin
               if (restart) begin
                  r_idx   <= '0;
                  r_retry <= '0;
                  r_fault <= 1'b0;
                  if (N_USED == 0) begin
                     r_state <= S_RELEASE;
                     r_run   <= 1'b1;
                     r_halt  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ISSUE;
                     r_halt  <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_ISSUE;
            end
         endcase
      end
   end

   assign csr_start   = r_start;
   assign csr_addr    = r_addr;
   assign csr_wdata   = r_wdata;
   assign halt_req    = r_halt;
   assign run_pulse   = r_run;
   assign init_done   = r_done;
   assign init_fault  = r_fault;
   assign fault_index = r_fidx;

endmodule

// File: tb/tb_carbon_init_seq.sv
// ---------------------------------------------------------------------------
// tb_carbon_init_seq
//
// Bench for carbon_init_seq. A three-entry table is run against a CSR
// responder that completes each access two cycles after its strobe and can
// be told to fault a given entry a number of times. Expected strobes and
// release pulses are queued by the stimulus and consumed by a monitor that
// compares them as the DUT produces them. A second instance with an empty
// table checks the immediate release.
// ---------------------------------------------------------------------------
module tb_carbon_init_seq;

   localparam logic [31:0] TB_ADDR [8] = '{32'h0000_1000, 32'h0000_1004,
                                           32'h0000_1008, 32'h0000_100C,
                                           32'h0000_1010, 32'h0000_1014,
                                           32'h0000_1018, 32'h0000_101C};
   localparam logic [31:0] TB_DATA [8] = '{32'hC0DE_0000, 32'hC0DE_0011,
                                           32'hC0DE_0022, 32'hC0DE_0033,
                                           32'hC0DE_0044, 32'hC0DE_0055,
                                           32'hC0DE_0066, 32'hC0DE_0077};
   localparam int LIMIT = 400;

   logic        clk;
   logic        rst;
   logic        restart;
   logic        csr_start;
   logic        csr_write;
   logic [31:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_busy;
   logic        csr_done;
   logic        csr_fault;
   logic [31:0] csr_rdata;
   logic        halt_req;
   logic        run_pulse;
   logic        init_done;
   logic        init_fault;
   logic [7:0]  fault_index;

   logic        d0_start;
   logic        d0_write;
   logic [31:0] d0_addr;
   logic [31:0] d0_wdata;
   logic        d0_halt;
   logic        d0_run;
   logic        d0_done;
   logic        d0_fault;
   logic [7:0]  d0_fidx;
   logic        d0_csr_done;
   logic        d0_csr_fault;
   logic [31:0] d0_csr_rdata;

   typedef struct packed {
      logic        kind;   // 0 = csr_start, 1 = run_pulse
      logic [31:0] addr;
      logic [31:0] wdata;
   } ev_t;

   ev_t q[$];
   int  n_tests;
   int  n_fail;
   int  fplan [8];
   int  plan_gen;
   int  stray_gen;

   carbon_init_seq #(
      .N_ENTRIES (8),
      .N_USED    (3),
      .INIT_ADDR (TB_ADDR),
      .INIT_WDATA(TB_DATA),
      .MAX_RETRY (2)
   ) u_dut (
      .clk(clk), .rst(rst), .restart(restart),
      .csr_start(csr_start), .csr_write(csr_write),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_busy(csr_busy), .csr_done(csr_done),
      .csr_fault(csr_fault), .csr_rdata(csr_rdata),
      .halt_req(halt_req), .run_pulse(run_pulse),
      .init_done(init_done), .init_fault(init_fault),
      .fault_index(fault_index)
   );

   carbon_init_seq #(
      .N_ENTRIES(8),
      .N_USED   (0),
      .MAX_RETRY(2)
   ) u_dut0 (
      .clk(clk), .rst(rst), .restart(restart),
      .csr_start(d0_start), .csr_write(d0_write),
      .csr_addr(d0_addr), .csr_wdata(d0_wdata),
      .csr_busy(csr_busy), .csr_done(d0_csr_done),
      .csr_fault(d0_csr_fault), .csr_rdata(d0_csr_rdata),
      .halt_req(d0_halt), .run_pulse(d0_run),
      .init_done(d0_done), .init_fault(d0_fault),
      .fault_index(d0_fidx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign d0_csr_done  = 1'b0;
   assign d0_csr_fault = 1'b0;
   assign d0_csr_rdata = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %h, expected no such event", nm, act);
   endtask

   task automatic push_start(input int i);
      ev_t e;
      e.kind  = 1'b0;
      e.addr  = TB_ADDR[i];
      e.wdata = TB_DATA[i];
      q.push_back(e);
   endtask

   task automatic push_release();
      ev_t e;
      e.kind  = 1'b1;
      e.addr  = 32'h0;
      e.wdata = 32'h0;
      q.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_start"}, 32'(csr_start), 32'd0);
      chk({tag, "_write"}, 32'(csr_write), 32'd1);
      chk({tag, "_addr"},  csr_addr,  32'd0);
      chk({tag, "_wdata"}, csr_wdata, 32'd0);
      chk({tag, "_halt"},  32'(halt_req),   32'd1);
      chk({tag, "_run"},   32'(run_pulse),  32'd0);
      chk({tag, "_done"},  32'(init_done),  32'd0);
      chk({tag, "_fault"}, 32'(init_fault), 32'd0);
      chk({tag, "_fidx"},  32'(fault_index), 32'd0);
   endtask

   // which: 0 = init_done, 1 = init_fault, 2 = csr_start of entry at addr a
   function automatic logic cond(input int which, input logic [31:0] a);
      if (which == 0) return init_done;
      if (which == 1) return init_fault;
      return csr_start && (csr_addr == a);
   endfunction

   task automatic wait_for(input int which, input logic [31:0] a, input string nm);
      int n;
      n = 0;
      while (!cond(which, a) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) bad({"timeout_", nm}, 32'(n));
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   // CSR responder: done two cycles after a strobe, faulting per plan.
   initial begin
      int cnt;
      int idx;
      int gen_seen;
      int stray_seen;
      int att [8];
      logic [31:0] a;
      cnt = 0;
      gen_seen = 0;
      stray_seen = 0;
      a = 32'h0;
      foreach (att[i]) att[i] = 0;
      csr_done  = 1'b0;
      csr_fault = 1'b0;
      csr_rdata = 32'h0;
      forever begin
         @(negedge clk);
         csr_done  = 1'b0;
         csr_fault = 1'b0;
         if (plan_gen != gen_seen) begin
            gen_seen = plan_gen;
            foreach (att[i]) att[i] = 0;
         end
         if (rst) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  idx = int'((a - 32'h0000_1000) >> 2);
                  csr_done = 1'b1;
                  if (idx >= 0 && idx < 8) begin
                     if (att[idx] < fplan[idx]) csr_fault = 1'b1;
                     att[idx]++;
                  end
               end
            end
            if (csr_start) begin
               cnt = 2;
               a = csr_addr;
            end
            if (stray_gen != stray_seen) begin
               stray_seen = stray_gen;
               csr_done = 1'b1;
            end
         end
      end
   end

   // Monitor: every strobe and release pulse must match the queue head.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (csr_start) begin
            if (q.size() == 0) begin
               bad("start_unexpected", csr_addr);
            end else begin
               e = q.pop_front();
               chk("ev_kind_start", 32'(e.kind), 32'd0);
               chk("start_addr",  csr_addr,  e.addr);
               chk("start_wdata", csr_wdata, e.wdata);
               chk("start_write", 32'(csr_write), 32'd1);
            end
         end
         if (run_pulse) begin
            if (q.size() == 0) begin
               bad("run_pulse_unexpected", 32'(run_pulse));
            end else begin
               e = q.pop_front();
               chk("ev_kind_release", 32'(e.kind), 32'd1);
               chk("release_halt", 32'(halt_req),  32'd0);
               chk("release_done", 32'(init_done), 32'd1);
            end
         end
      end
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      plan_gen  = 0;
      stray_gen = 0;
      foreach (fplan[i]) fplan[i] = 0;
      rst      = 1'b1;
      restart  = 1'b0;
      csr_busy = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values on both instances.
      chk_reset_outputs("rst");
      chk("d0_rst_halt", 32'(d0_halt), 32'd1);
      chk("d0_rst_run",  32'(d0_run),  32'd0);

      // Clean run with csr_busy high for 5 cycles after reset.
      push_start(0); push_start(1); push_start(2); push_release();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("busy_no_start", 32'(csr_start), 32'd0);
         chk("d0_no_start",   32'(d0_start),  32'd0);
         if (k == 0) chk("d0_release_run", 32'(d0_run), 32'd1);
         if (k == 1) begin
            chk("d0_run_once", 32'(d0_run),  32'd0);
            chk("d0_done",     32'(d0_done), 32'd1);
            chk("d0_halt",     32'(d0_halt), 32'd0);
         end
      end
      csr_busy = 1'b0;
      @(negedge clk);
      chk("start_after_busy", 32'(csr_start), 32'd1);
      wait_for(0, 32'h0, "run1_done");
      @(negedge clk);
      chk("run1_halt",  32'(halt_req),   32'd0);
      chk("run1_done",  32'(init_done),  32'd1);
      chk("run1_fault", 32'(init_fault), 32'd0);
      chk("run1_q",     32'(q.size()),   32'd0);

      // Stray csr_done while in DONE changes nothing.
      stray_gen++;
      repeat (5) @(negedge clk);
      chk("stray_done", 32'(init_done), 32'd1);
      chk("stray_halt", 32'(halt_req),  32'd0);
      chk("stray_q",    32'(q.size()),  32'd0);

      // Entry 1 faults twice: issued three times, then completes.
      fplan[1] = 2;
      plan_gen++;
      push_start(0); push_start(1); push_start(1); push_start(1);
      push_start(2); push_release();
      pulse_restart();
      chk("restart_halt", 32'(halt_req),  32'd1);
      chk("restart_done", 32'(init_done), 32'd0);
      wait_for(0, 32'h0, "retry_done");
      @(negedge clk);
      chk("retry_done",  32'(init_done),  32'd1);
      chk("retry_fault", 32'(init_fault), 32'd0);
      chk("retry_q",     32'(q.size()),   32'd0);

      // Entry 2 faults three times: table aborts at entry 2.
      fplan[1] = 0;
      fplan[2] = 3;
      plan_gen++;
      push_start(0); push_start(1); push_start(2); push_start(2); push_start(2);
      pulse_restart();
      wait_for(1, 32'h0, "abort_fault");
      repeat (4) @(negedge clk);
      chk("abort_fault", 32'(init_fault),  32'd1);
      chk("abort_fidx",  32'(fault_index), 32'd2);
      chk("abort_halt",  32'(halt_req),    32'd1);
      chk("abort_done",  32'(init_done),   32'd0);
      chk("abort_q",     32'(q.size()),    32'd0);

      // Restart from FAULT reruns from entry 0; restart mid-run is ignored.
      fplan[2] = 0;
      plan_gen++;
      push_start(0); push_start(1); push_start(2); push_release();
      pulse_restart();
      chk("rerun_fault_clr", 32'(init_fault), 32'd0);
      chk("rerun_halt",      32'(halt_req),   32'd1);
      wait_for(2, TB_ADDR[0], "rerun_start0");
      pulse_restart();
      wait_for(0, 32'h0, "rerun_done");
      @(negedge clk);
      chk("rerun_done", 32'(init_done), 32'd1);
      chk("rerun_q",    32'(q.size()),  32'd0);

      // Reset while waiting on entry 1 abandons the access.
      push_start(0); push_start(1);
      pulse_restart();
      wait_for(2, TB_ADDR[1], "midrst_start1");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      chk("midrst_q", 32'(q.size()), 32'd0);
      @(negedge clk);
      push_start(0); push_start(1); push_start(2); push_release();
      rst = 1'b0;
      wait_for(0, 32'h0, "midrst_done");
      @(negedge clk);
      chk("midrst_done", 32'(init_done), 32'd1);
      chk("midrst_halt", 32'(halt_req),  32'd0);
      chk("final_q",     32'(q.size()),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
